// File: rtl/wishbone_peripheral_bridge.sv
// Wishbone classic slave to 24-bit peripheral bus bridge: one peripheral transfer
// per Wishbone cycle, with a busy-wait timeout and cycle-abort handling.
module wishbone_peripheral_bridge #(
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [23:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o,
  output logic        peripheralBus_we,
  output logic        peripheralBus_oe,
  output logic [23:0] peripheralBus_address,
  output logic [3:0]  peripheralBus_byteSelect,
  output logic [31:0] peripheralBus_dataWrite,
  input  logic        peripheralBus_busy,
  input  logic [31:0] peripheralBus_dataRead,
  input  logic        peripheralBus_requestOutput
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, ERR} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] COUNT_MAX = '1;

  state_t                   state;
  logic [TIMEOUT_WIDTH-1:0] count;

  // The claim flag is advisory; an unclaimed read still completes with mux data.
  logic unused_request;
  assign unused_request = peripheralBus_requestOutput;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      count                    <= '0;
      wb_ack_o                 <= 1'b0;
      wb_err_o                 <= 1'b0;
      wb_dat_o                 <= '0;
      peripheralBus_we         <= 1'b0;
      peripheralBus_oe         <= 1'b0;
      peripheralBus_address    <= '0;
      peripheralBus_byteSelect <= '0;
      peripheralBus_dataWrite  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          if (wb_cyc_i && wb_stb_i) begin
            peripheralBus_address    <= wb_adr_i;
            peripheralBus_byteSelect <= wb_sel_i;
            peripheralBus_dataWrite  <= wb_dat_i;
            peripheralBus_we         <= wb_we_i;
            peripheralBus_oe         <= ~wb_we_i;
            state                    <= ACCESS;
          end
        end
        ACCESS: begin
          // Abort outranks completion and timeout in the same cycle.
          if (!wb_cyc_i) begin
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
            count            <= '0;
            state            <= IDLE;
          end else if (!peripheralBus_busy) begin
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
            if (peripheralBus_oe) wb_dat_o <= peripheralBus_dataRead;
            wb_ack_o <= 1'b1;
            state    <= ACK;
          end else if (count == COUNT_MAX) begin
            peripheralBus_we <= 1'b0;
            peripheralBus_oe <= 1'b0;
            if (peripheralBus_oe) wb_dat_o <= 32'hFFFF_FFFF;
            wb_err_o <= 1'b1;
            state    <= ERR;
          end else begin
            count <= count + 1'b1;
          end
        end
        ACK: begin
          wb_ack_o <= 1'b0;
          count    <= '0;
          state    <= IDLE;
        end
        ERR: begin
          wb_err_o <= 1'b0;
          count    <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_peripheral_bridge.sv
// Directed bench for wishbone_peripheral_bridge: write, read, stall, timeout,
// abort, mid-transfer reset and back-to-back transfers.
module tb_wishbone_peripheral_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [23:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic        pb_we, pb_oe;
  logic [23:0] pb_adr;
  logic [3:0]  pb_sel;
  logic [31:0] pb_dw;
  logic        pb_busy;
  logic [31:0] pb_dr;
  logic        pb_req;

  int tests = 0;
  int fails = 0;

  wishbone_peripheral_bridge #(.TIMEOUT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
    .peripheralBus_we(pb_we), .peripheralBus_oe(pb_oe),
    .peripheralBus_address(pb_adr), .peripheralBus_byteSelect(pb_sel),
    .peripheralBus_dataWrite(pb_dw), .peripheralBus_busy(pb_busy),
    .peripheralBus_dataRead(pb_dr), .peripheralBus_requestOutput(pb_req)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [23:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
  endtask

  task automatic release_bus;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick;
    tests++; if ({pb_we, pb_oe, wb_ack_o, wb_err_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_strobes got %b expected 0000", {pb_we, pb_oe, wb_ack_o, wb_err_o}); end
    tests++; if ({pb_adr, pb_sel, pb_dw, wb_dat_o} !== 92'd0) begin
      fails++; $display("FAIL reset_data got adr=%h sel=%h dw=%h dat=%h expected all 0", pb_adr, pb_sel, pb_dw, wb_dat_o); end
    rst = 1'b0;
  endtask

  task automatic test_read;
    pb_busy = 1'b0; pb_dr = 32'h1234_5678; pb_req = 1'b1;
    request(1'b0, 24'h000010, 4'hF, 32'h0);
    tick;
    tests++; if ({pb_oe, pb_we} !== 2'b10) begin
      fails++; $display("FAIL read_strobe got oe,we=%b expected 10", {pb_oe, pb_we}); end
    tick;
    tests++; if ({pb_oe, wb_ack_o, wb_err_o} !== 3'b010) begin
      fails++; $display("FAIL read_ack got oe,ack,err=%b expected 010", {pb_oe, wb_ack_o, wb_err_o}); end
    tests++; if (wb_dat_o !== 32'h1234_5678) begin
      fails++; $display("FAIL read_data got %h expected 12345678", wb_dat_o); end
    release_bus; tick;
    tests++; if (wb_ack_o !== 1'b0) begin
      fails++; $display("FAIL read_ack_pulse got %b expected 0", wb_ack_o); end
    // unclaimed read: the mux shows all-ones
    pb_dr = 32'hFFFF_FFFF; pb_req = 1'b0;
    request(1'b0, 24'h0FFF00, 4'hF, 32'h0);
    tick; tick;
    tests++; if ({wb_ack_o, wb_err_o} !== 2'b10 || wb_dat_o !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL unclaimed_read got ack,err=%b dat=%h expected 10 ffffffff", {wb_ack_o, wb_err_o}, wb_dat_o); end
    release_bus; tick;
    pb_dr = 32'h1234_5678;
  endtask

  task automatic test_write;
    // previous read left ffffffff in wb_dat_o; write must not touch it
    request(1'b1, 24'h031004, 4'hF, 32'hA5A5_0F0F);
    tick;
    tests++; if ({pb_we, pb_oe, wb_ack_o} !== 3'b100) begin
      fails++; $display("FAIL write_strobe got we,oe,ack=%b expected 100", {pb_we, pb_oe, wb_ack_o}); end
    tests++; if (pb_adr !== 24'h031004 || pb_sel !== 4'hF || pb_dw !== 32'hA5A5_0F0F) begin
      fails++; $display("FAIL write_fields got adr=%h sel=%h dw=%h expected 031004 f a5a50f0f", pb_adr, pb_sel, pb_dw); end
    tick;
    tests++; if ({pb_we, wb_ack_o} !== 2'b01) begin
      fails++; $display("FAIL write_ack got we,ack=%b expected 01", {pb_we, wb_ack_o}); end
    tests++; if (wb_dat_o !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL write_keeps_dat got %h expected ffffffff", wb_dat_o); end
    tests++; if (pb_adr !== 24'h031004 || pb_dw !== 32'hA5A5_0F0F) begin
      fails++; $display("FAIL write_hold got adr=%h dw=%h expected 031004 a5a50f0f", pb_adr, pb_dw); end
    release_bus; tick;
    // no byte lanes selected still runs the transfer
    request(1'b1, 24'h000204, 4'h0, 32'h0000_00C3);
    tick;
    tests++; if (pb_we !== 1'b1 || pb_sel !== 4'h0 || pb_adr !== 24'h000204) begin
      fails++; $display("FAIL sel_zero got we=%b sel=%h adr=%h expected 1 0 000204", pb_we, pb_sel, pb_adr); end
    tick;
    tests++; if (wb_ack_o !== 1'b1) begin
      fails++; $display("FAIL sel_zero_ack got %b expected 1", wb_ack_o); end
    release_bus; tick;
  endtask

  task automatic test_busy_stall;
    int strobe_cycles = 0, acks = 0, ack_cycle = 0;
    pb_busy = 1'b1; pb_dr = 32'hCAFE_BABE; pb_req = 1'b1;
    request(1'b0, 24'h000040, 4'hF, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 4) pb_busy = 1'b0;
      if (pb_oe) strobe_cycles++;
      if (wb_ack_o) begin acks++; ack_cycle = c; release_bus; end
    end
    tests++; if (strobe_cycles != 4) begin
      fails++; $display("FAIL stall_strobe_len got %0d expected 4", strobe_cycles); end
    tests++; if (acks != 1 || ack_cycle != 5) begin
      fails++; $display("FAIL stall_ack got count=%0d cycle=%0d expected 1 at 5", acks, ack_cycle); end
    tests++; if (wb_dat_o !== 32'hCAFE_BABE) begin
      fails++; $display("FAIL stall_data got %h expected cafebabe", wb_dat_o); end
  endtask

  task automatic test_timeout;
    int strobe_cycles = 0, acks = 0, errs = 0, err_cycle = 0;
    pb_busy = 1'b1; pb_dr = 32'h0BAD_F00D; pb_req = 1'b1;
    request(1'b0, 24'h000080, 4'hF, 32'h0);
    for (int c = 1; c <= 300; c++) begin
      tick;
      if (pb_oe) strobe_cycles++;
      if (wb_ack_o) acks++;
      if (wb_err_o) begin errs++; err_cycle = c; release_bus; end
    end
    tests++; if (errs != 1 || err_cycle != 257) begin
      fails++; $display("FAIL timeout_err got count=%0d cycle=%0d expected 1 at 257", errs, err_cycle); end
    tests++; if (strobe_cycles != 256 || acks != 0) begin
      fails++; $display("FAIL timeout_strobe got strobe=%0d acks=%0d expected 256 0", strobe_cycles, acks); end
    tests++; if (wb_dat_o !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL timeout_data got %h expected ffffffff", wb_dat_o); end
    release_bus;
    pb_busy = 1'b0; pb_dr = 32'h55AA_55AA;
    request(1'b0, 24'h000084, 4'hF, 32'h0);
    tick; tick;
    tests++; if ({wb_ack_o, wb_err_o} !== 2'b10 || wb_dat_o !== 32'h55AA_55AA) begin
      fails++; $display("FAIL after_timeout got ack,err=%b dat=%h expected 10 55aa55aa", {wb_ack_o, wb_err_o}, wb_dat_o); end
    release_bus; tick;
  endtask

  task automatic test_abort;
    int acks = 0, errs = 0;
    pb_busy = 1'b1; pb_dr = 32'h9999_0000;
    request(1'b0, 24'h000100, 4'hF, 32'h0);
    tick; tick;
    release_bus;
    tick;
    tests++; if ({pb_we, pb_oe} !== 2'b00) begin
      fails++; $display("FAIL abort_strobe got we,oe=%b expected 00", {pb_we, pb_oe}); end
    for (int c = 0; c < 4; c++) begin
      if (wb_ack_o) acks++;
      if (wb_err_o) errs++;
      tick;
    end
    tests++; if (acks != 0 || errs != 0) begin
      fails++; $display("FAIL abort_no_resp got acks=%0d errs=%0d expected 0 0", acks, errs); end
    tests++; if (wb_dat_o !== 32'h55AA_55AA) begin
      fails++; $display("FAIL abort_keeps_dat got %h expected 55aa55aa", wb_dat_o); end
  endtask

  task automatic test_reset_mid;
    pb_busy = 1'b1; pb_dr = 32'h1111_1111;
    request(1'b1, 24'h000300, 4'h3, 32'hDEAD_BEEF);
    tick;
    rst = 1'b1;
    tick;
    tests++; if ({pb_we, pb_oe, wb_ack_o, wb_err_o} !== 4'b0000 ||
                 {pb_adr, pb_sel, pb_dw, wb_dat_o} !== 92'd0) begin
      fails++; $display("FAIL reset_mid got we,oe,ack,err=%b adr=%h sel=%h dw=%h dat=%h expected all 0",
                        {pb_we, pb_oe, wb_ack_o, wb_err_o}, pb_adr, pb_sel, pb_dw, wb_dat_o); end
    release_bus; tick; rst = 1'b0;
    pb_busy = 1'b0; pb_dr = 32'h8765_4321;
    request(1'b0, 24'h000304, 4'hF, 32'h0);
    tick;
    tests++; if (pb_oe !== 1'b1 || pb_adr !== 24'h000304) begin
      fails++; $display("FAIL reset_fresh_strobe got oe=%b adr=%h expected 1 000304", pb_oe, pb_adr); end
    tick;
    tests++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h8765_4321) begin
      fails++; $display("FAIL reset_fresh_read got ack=%b dat=%h expected 1 87654321", wb_ack_o, wb_dat_o); end
    release_bus; tick;
  endtask

  task automatic test_back_to_back;
    int n_ack = 0, both = 0, oe_rises = 0;
    int ack_at[2];
    int oe_at[2];
    logic [31:0] dat_at[2];
    logic prev_oe = 1'b0;
    pb_busy = 1'b0; pb_dr = 32'h0000_0001;
    request(1'b0, 24'h000500, 4'hF, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 3) pb_dr = 32'h0000_0002;
      if (pb_we && pb_oe) both++;
      if (pb_oe && !prev_oe && oe_rises < 2) begin oe_at[oe_rises] = c; oe_rises++; end
      prev_oe = pb_oe;
      if (wb_ack_o && n_ack < 2) begin
        ack_at[n_ack] = c; dat_at[n_ack] = wb_dat_o; n_ack++;
        if (n_ack == 2) release_bus;
      end
    end
    tests++; if (n_ack != 2 || ack_at[0] != 2 || ack_at[1] != 5) begin
      fails++; $display("FAIL b2b_ack got count=%0d at %0d,%0d expected 2 at 2,5", n_ack, ack_at[0], ack_at[1]); end
    tests++; if (oe_rises != 2 || oe_at[1] != 4) begin
      fails++; $display("FAIL b2b_second_strobe got rises=%0d second at %0d expected 2 at 4", oe_rises, oe_at[1]); end
    tests++; if (dat_at[0] !== 32'h1 || dat_at[1] !== 32'h2) begin
      fails++; $display("FAIL b2b_data got %h,%h expected 00000001,00000002", dat_at[0], dat_at[1]); end
    tests++; if (both != 0) begin
      fails++; $display("FAIL we_oe_exclusive got %0d overlaps expected 0", both); end
  endtask

  initial begin
    rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = '0; wb_adr_i = '0; wb_dat_i = '0;
    pb_busy = 1'b0; pb_dr = '1; pb_req = 1'b0;
    test_reset;
    test_read;
    test_write;
    test_busy_stall;
    test_timeout;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
